// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse receiver: synchronises the line pair, deserialises 11-bit frames,
// assembles 3-byte stream packets and emits per-packet sign/magnitude deltas.
module ps2_mouse_packet_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_mouse_dx,
  output logic [7:0] o_mouse_dy,
  output logic       o_is_mouse_dx_neg,
  output logic       o_is_mouse_dy_neg,
  output logic [2:0] o_buttons,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   clk_prev_reg;
  logic                   fall;
  logic                   data_bit;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       par_err_reg, par_err_next;
  logic       byte_done;
  logic       frame_bad;

  logic [CNT_W-1:0] cnt_reg;
  logic             active;
  logic             timeout;

  logic [1:0] idx_reg;
  logic [7:0] byte0_reg;
  logic [7:0] byte1_reg;
  logic [7:0] dx_reg, dy_reg;
  logic       dx_neg_reg, dy_neg_reg;
  logic [2:0] buttons_reg;
  logic       valid_reg, err_reg;

  // Synchronisers idle high so that reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
      clk_prev_reg  <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], i_ps2_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], i_ps2_data};
      clk_prev_reg  <= clk_sync_reg[SYNC_STAGES-1];
    end
  end

  assign fall     = clk_prev_reg & ~clk_sync_reg[SYNC_STAGES-1];
  assign data_bit = data_sync_reg[SYNC_STAGES-1];

  assign active  = (state_reg != IDLE) || (idx_reg != 2'd0);
  assign timeout = active && !fall && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_reg <= '0;
    end else if (fall || !active || timeout) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'd0;
      par_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      par_err_reg <= par_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    par_err_next = par_err_reg;
    byte_done    = 1'b0;
    frame_bad    = 1'b0;
    if (timeout) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state_reg)
        IDLE: begin
          if (!data_bit) begin
            state_next   = DATA;
            bit_cnt_next = 3'd0;
          end
        end
        DATA: begin
          shift_next   = {data_bit, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          // Odd parity: data plus parity bit must hold an odd number of ones.
          par_err_next = ~(^shift_reg ^ data_bit);
          state_next   = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (data_bit && !par_err_reg) byte_done = 1'b1;
          else                          frame_bad = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Nine-bit two's complement to saturated magnitude; -256 folds to 255.
  function automatic logic [7:0] to_mag(input logic sign, input logic [7:0] b,
                                        input logic ovf);
    logic [8:0] neg;
    neg = 9'd0 - {sign, b};
    if (ovf)           return 8'hFF;
    else if (!sign)    return b;
    else if (neg[8])   return 8'hFF;
    else               return neg[7:0];
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      idx_reg     <= 2'd0;
      byte0_reg   <= 8'd0;
      byte1_reg   <= 8'd0;
      dx_reg      <= 8'd0;
      dy_reg      <= 8'd0;
      dx_neg_reg  <= 1'b0;
      dy_neg_reg  <= 1'b0;
      buttons_reg <= 3'd0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
      dx_reg     <= 8'd0;
      dy_reg     <= 8'd0;
      dx_neg_reg <= 1'b0;
      dy_neg_reg <= 1'b0;
      if (timeout || frame_bad) begin
        idx_reg <= 2'd0;
        err_reg <= 1'b1;
      end else if (byte_done) begin
        case (idx_reg)
          2'd0: begin
            if (shift_reg[3]) begin
              byte0_reg <= shift_reg;
              idx_reg   <= 2'd1;
            end else begin
              err_reg <= 1'b1;
            end
          end
          2'd1: begin
            byte1_reg <= shift_reg;
            idx_reg   <= 2'd2;
          end
          default: begin
            idx_reg     <= 2'd0;
            valid_reg   <= 1'b1;
            dx_reg      <= to_mag(byte0_reg[4], byte1_reg, byte0_reg[6]);
            dy_reg      <= to_mag(byte0_reg[5], shift_reg, byte0_reg[7]);
            dx_neg_reg  <= byte0_reg[4];
            dy_neg_reg  <= byte0_reg[5];
            buttons_reg <= byte0_reg[2:0];
          end
        endcase
      end
    end
  end

  assign o_mouse_dx        = dx_reg;
  assign o_mouse_dy        = dy_reg;
  assign o_is_mouse_dx_neg = dx_neg_reg;
  assign o_is_mouse_dy_neg = dy_neg_reg;
  assign o_buttons         = buttons_reg;
  assign o_valid           = valid_reg;
  assign o_frame_err       = err_reg;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Bench for ps2_mouse_packet_decoder: drives PS/2 frames and compares decoded
// packets against an arithmetic model of the movement encoding.
module tb_ps2_mouse_packet_decoder;

  localparam int TIMEOUT = 300;
  localparam int HALF    = 10;
  localparam int GAP     = 40;

  logic       clk;
  logic       arst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] mouse_dx;
  logic [7:0] mouse_dy;
  logic       dx_neg;
  logic       dy_neg;
  logic [2:0] buttons;
  logic       valid;
  logic       frame_err;

  typedef struct {
    int dx;
    int dy;
    int dxn;
    int dyn;
    int btn;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   err_seen = 0;
  int   exp_err  = 0;
  int   last_btn = 0;

  ps2_mouse_packet_decoder #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .i_ps2_clk        (ps2_clk),
    .i_ps2_data       (ps2_data),
    .o_mouse_dx       (mouse_dx),
    .o_mouse_dy       (mouse_dy),
    .o_is_mouse_dx_neg(dx_neg),
    .o_is_mouse_dy_neg(dy_neg),
    .o_buttons        (buttons),
    .o_valid          (valid),
    .o_frame_err      (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: signed 9-bit delta -> magnitude, saturated, overflow forces 255.
  function automatic int ref_mag(input int b, input int sign, input int ovf);
    int v;
    v = sign ? b - 256 : b;
    if (v < 0) v = -v;
    if (ovf != 0 || v > 255) return 255;
    return v;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (GAP) @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    int   i0;
    i0    = int'(b0);
    e.dx  = ref_mag(int'(b1), (i0 >> 4) & 1, (i0 >> 6) & 1);
    e.dy  = ref_mag(int'(b2), (i0 >> 5) & 1, (i0 >> 7) & 1);
    e.dxn = (i0 >> 4) & 1;
    e.dyn = (i0 >> 5) & 1;
    e.btn = i0 & 7;
    exp_q.push_back(e);
    last_btn = e.btn;
    $display("packet %02h %02h %02h -> dx=%0d dxn=%0d dy=%0d dyn=%0d btn=%0d",
             b0, b1, b2, e.dx, e.dxn, e.dy, e.dyn, e.btn);
    send_frame(b0, 1'b0, 11);
    send_frame(b1, 1'b0, 11);
    send_frame(b2, 1'b0, 11);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_val({tag, "_pending"}, exp_q.size(), 0);
    check_val({tag, "_errs"}, err_seen, exp_err);
    check_val({tag, "_buttons"}, int'(buttons), last_btn);
  endtask

  always @(negedge clk) begin
    if (arst_n) begin
      check_val("strobe_excl", int'(valid & frame_err), 0);
      if (frame_err) err_seen++;
      if (valid) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_valid", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("dx", int'(mouse_dx), e.dx);
          check_val("dy", int'(mouse_dy), e.dy);
          check_val("dx_neg", int'(dx_neg), e.dxn);
          check_val("dy_neg", int'(dy_neg), e.dyn);
          check_val("buttons", int'(buttons), e.btn);
        end
      end else begin
        check_val("idle_zero", int'({mouse_dx, mouse_dy, dx_neg, dy_neg}), 0);
      end
    end
  end

  initial begin
    logic [7:0] r0, r1, r2;
    arst_n   = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("reset_outputs",
              int'({mouse_dx, mouse_dy, dx_neg, dy_neg, buttons, valid, frame_err}), 0);
    #1 arst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    send_packet(8'h08, 8'h05, 8'h00);
    settle_and_check("clean");
    send_packet(8'h18, 8'h00, 8'h00);
    send_packet(8'h48, 8'h01, 8'h7F);
    send_packet(8'h39, 8'hFB, 8'h02);
    settle_and_check("signs");

    // Bad parity on byte 1, then a clean packet.
    $display("bad parity on byte 1");
    send_frame(8'h09, 1'b0, 11);
    send_frame(8'h44, 1'b1, 11);
    exp_err++;
    send_packet(8'h0A, 8'h10, 8'h20);
    settle_and_check("parity");

    $display("misaligned byte 00");
    send_frame(8'h00, 1'b0, 11);
    exp_err++;
    send_packet(8'h08, 8'h03, 8'h01);
    settle_and_check("align");

    $display("timeout after 4 data bits");
    send_frame(8'h08, 1'b0, 5);
    repeat (TIMEOUT + 10) @(posedge clk);
    #1;
    exp_err++;
    send_packet(8'h2C, 8'h80, 8'hFF);
    settle_and_check("timeout");

    // Reset mid-byte-1: partial packet dropped, outputs cleared, no strobe.
    $display("reset during byte 1");
    send_frame(8'h0F, 1'b0, 11);
    send_frame(8'h33, 1'b0, 6);
    #1 arst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("midrst_outputs",
              int'({mouse_dx, mouse_dy, dx_neg, dy_neg, buttons, valid, frame_err}), 0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    #1 arst_n = 1'b1;
    last_btn = 0;
    repeat (10) @(posedge clk);
    #1;
    send_packet(8'h0B, 8'h07, 8'h09);
    settle_and_check("midrst");

    for (int n = 0; n < 20; n++) begin
      r0 = 8'($urandom) | 8'h08;
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      send_packet(r0, r1, r2);
    end
    settle_and_check("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    failures++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet_decoder.md
# ps2_mouse_packet_decoder

Receive-only PS/2 mouse front end that converts the raw PS/2 clock/data line pair into per-packet movement strobes for the game engines. It synchronises the lines, deserialises 11-bit frames, checks framing and parity, assembles standard 3-byte stream-mode packets, and emits sign/magnitude X and Y deltas. It sits directly upstream of `second_game_engine` and drives that block's `i_mouse_dx`, `i_mouse_dy`, `i_is_mouse_dx_neg` and `i_is_mouse_dy_neg` inputs.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on each PS/2 input, minimum 2.
- `TIMEOUT_CYCLES`, default 50000: idle `clk` cycles (1 ms at 50 MHz) that abort a frame or packet in progress.
- `clk` input 1: system clock.
- `arst_n` input 1: reset, asynchronous, active-low.
- `i_ps2_clk` input 1: raw PS/2 clock, asynchronous to `clk`.
- `i_ps2_data` input 1: raw PS/2 data, asynchronous to `clk`.
- `o_mouse_dx` output 8: X movement magnitude, saturated. Non-zero only while `o_valid` is high.
- `o_mouse_dy` output 8: Y movement magnitude, saturated. Non-zero only while `o_valid` is high.
- `o_is_mouse_dx_neg` output 1: X sign (packet byte0 bit4). Meaningful only while `o_valid` is high, 0 otherwise.
- `o_is_mouse_dy_neg` output 1: Y sign (packet byte0 bit5). Meaningful only while `o_valid` is high, 0 otherwise.
- `o_buttons` output 3: {middle, right, left} from byte0 bits [2:0]. Holds the last valid packet's value.
- `o_valid` output 1: one-cycle strobe when a complete packet is accepted.
- `o_frame_err` output 1: one-cycle strobe on any framing, parity, alignment or timeout error.

## Operation
- **Input synchronisation**
  - Both inputs pass through `SYNC_STAGES` flops, then one extra register for edge detection.
  - A falling edge of the synchronised PS/2 clock is the only sampling event. Data is sampled in the same cycle.
- **Frame FSM**
  - States: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bit counter 0. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: compute odd parity over the 8 data bits plus the parity bit. Latch the mismatch flag and go to STOP.
  - STOP: if stop=1 and parity is good, the byte is accepted. Otherwise raise an error. Either way return to IDLE.
- **Timeout counter**
  - Clears on every falling edge.
  - Counts while the FSM is outside IDLE, or while the packet index is non-zero.
  - On reaching `TIMEOUT_CYCLES`: FSM goes to IDLE, packet index goes to 0, and one error strobe is raised.
- **Packet assembly** (index 0..2)
  - Byte at index 0 must have bit3=1. Otherwise discard it, raise an error, and keep the index at 0.
  - Accepted bytes are stored at the current index and the index is incremented.
  - Accepting the byte at index 2 completes the packet and returns the index to 0.
  - Any frame error discards the partial packet and sets the index to 0.
- **Delta conversion**
  - Form a 9-bit two's complement value {sign, byte}; magnitude = abs value.
  - If the magnitude exceeds 255, output 255. A value of −256 therefore gives 255.
  - If the overflow bit is set (byte0 bit6 for X, bit7 for Y), the magnitude is 255 regardless of the byte.
  - A negative sign with magnitude 0 cannot occur. If the sign bit is set with byte 0x00, that is −256 and gives 255.
  - Y is passed in PS/2 convention (positive = up). The engine handles screen orientation.
- **Outputs outside the strobe**
  - `o_mouse_dx`, `o_mouse_dy` and both sign outputs are 0 in every cycle where `o_valid` is low. An engine that integrates every cycle therefore moves only once per packet.

## Timing
- **Reset values**
  - All outputs are 0; FSM is IDLE; packet index is 0; timeout counter is 0.
  - Synchroniser flops reset to 1 (idle bus level), so no false edge occurs after reset.
- **Latencies**
  - Edge detection latency: `SYNC_STAGES`+1 `clk` cycles after a raw falling edge.
  - `o_valid` and the deltas are registered. They rise in the cycle after the STOP-state sample of byte 2 and last exactly one cycle.
  - `o_frame_err` rises in the cycle after the offending sample, or after the timeout terminal count, and lasts one cycle.
- **Strobe exclusivity**
  - `o_valid` and `o_frame_err` are never high in the same cycle.
  - If a timeout and a falling edge coincide, the edge wins and the counter clears.
- **Reset mid-operation**
  - Asserting `arst_n` low during a frame or packet immediately forces all reset values.
  - The partial data is lost; no strobe is raised.
- **Throughput**
  - One packet per 33 PS/2 clocks; there is no back-pressure.
  - A new packet overwrites `o_buttons`.

## Test plan
- Clean packet 0x08, 0x05, 0x00 with correct parity -> one-cycle `o_valid`, dx=5, dx_neg=0, dy=0, dy_neg=0, buttons=0. No `o_frame_err`.
- Packet 0x39, 0xFB, 0x02 -> dx=5, dx_neg=1, dy=0xFE, dy_neg=1, buttons=3'b001. Packet 0x18, 0x00, 0x00 -> dx=255, dx_neg=1. Byte0 0x48 -> dx=255.
- Bad parity on byte 1, followed by a clean packet -> one `o_frame_err`, no `o_valid` for the bad packet, then `o_valid` for the clean one with its values.
- Misaligned stream 0x00, then 0x08, 0x03, 0x01 -> `o_frame_err` on 0x00, then `o_valid` with dx=3, dy=1.
- PS/2 clock stops after 4 data bits for `TIMEOUT_CYCLES`+10 cycles -> one `o_frame_err`, FSM in IDLE. The following clean packet decodes correctly.
- Reset asserted mid-byte-1 and then released, followed by a clean packet -> all outputs 0 during reset, then exactly one `o_valid` with the new packet's values.
